// File: rtl/aes_cipher.sv
// -----------------------------------------------------------------------------
// aes_cipher
// Iterative AES-128 encryption core. The round keys are not stored here. Each
// round, the core drives round_key_no to the external key SRAM, and the SRAM
// returns the matching key one clock later. Each of the 11 key additions takes
// a FETCH cycle followed by an APPLY cycle.
//
// Ports
//   clk           system clock, all state on rising edge
//   reset         asynchronous active-low reset
//   en            start strobe, sampled only in IDLE
//   plaintext     input block [0:127], bit 0 = MSB, byte k = [8k:8k+7]
//   key           round key from SRAM (sram[round_key_no], one clock late)
//   ciphertext    result block, held until the next completion or reset
//   round_key_no  round-key index 0..10 requested from the SRAM (registered)
//   en_o          one-cycle done pulse, ciphertext valid
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for en, round_key_no = 0
//   S_FETCH | round_key_no stable, SRAM produces key[counter] at cycle end
//   S_APPLY | key valid, apply round `counter` to the state register
//   S_DONE  | en_o high for this single cycle
// -----------------------------------------------------------------------------
module aes_cipher (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [0:127] plaintext,
    input  logic [0:127] key,
    output logic [0:127] ciphertext,
    output logic [0:3]   round_key_no,
    output logic         en_o
);

    localparam logic [3:0] NR = 4'd10;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic [0:127] r_blk;
    logic [0:127] r_ct;
    logic [0:127] w_sb;
    logic [0:127] w_sr;
    logic [0:127] w_mc;
    logic [0:127] w_round;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; a0 is the top (row 0) byte in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Round datapath: SubBytes -> ShiftRows -> MixColumns, then key selection.
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int k = 0; k < 16; k++) begin
            w_sb[8*k +: 8] = sbox(r_blk[8*k +: 8]);
        end
        // Byte (row r, column c) takes the byte from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[8*(4*c + r) +: 8] = w_sb[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[32*c +: 32] = mix_col(w_sr[32*c +: 32]);
        end
        if (r_cnt == 4'd0) begin
            w_round = r_blk ^ key;
        end else if (r_cnt == NR) begin
            w_round = w_sr ^ key;
        end else begin
            w_round = w_mc ^ key;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        en_o   = 1'b0;
        case (r_state)
            S_IDLE:  if (en) w_next = S_FETCH;
            S_FETCH: w_next = S_APPLY;
            S_APPLY: w_next = (r_cnt == NR) ? S_DONE : S_FETCH;
            S_DONE: begin
                en_o   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_blk <= '0;
            r_ct  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    if (en) r_blk <= plaintext;
                end
                S_APPLY: begin
                    r_blk <= w_round;
                    if (r_cnt == NR) begin
                        r_ct <= w_round;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE:  r_cnt <= 4'd0;
                default: ;
            endcase
        end
    end

    // The counter is itself a register, so the SRAM index is glitch-free.
    assign round_key_no = r_cnt;
    assign ciphertext   = r_ct;

endmodule

// File: tb/tb_aes_cipher.sv
module tb_aes_cipher;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [0:127] plaintext;
    logic [0:127] key = '0;
    logic [0:127] ciphertext;
    logic [0:3]   round_key_no;
    logic         en_o;

    aes_cipher dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .plaintext    (plaintext),
        .key          (key),
        .ciphertext   (ciphertext),
        .round_key_no (round_key_no),
        .en_o         (en_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        int           ksel;
        logic [127:0] ct;
    } vec_t;

    typedef struct {
        logic [127:0] ct;
        int           cyc;
    } exp_t;

    int           compared = 0;
    int           failed   = 0;
    int           cyc      = 0;
    int           sel      = 0;
    logic [0:2047] tb_sbox;
    logic [127:0] rk [3][11];
    exp_t         sb_q [$];
    vec_t         vec [3];

    always @(posedge clk) cyc <= cyc + 1;

    // Key SRAM: registered read, one clock after the index is presented.
    always @(posedge clk) begin
        if (int'(round_key_no) <= 10) key <= rk[sel][int'(round_key_no)];
    end

    function automatic logic [7:0] tb_sub(input logic [7:0] b);
        return tb_sbox[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sub(w[31:24]), tb_sub(w[23:16]), tb_sub(w[15:8]), tb_sub(w[7:0])};
    endfunction

    task automatic expand(input int idx, input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[idx][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) chk_int("rkno_bound", (int'(round_key_no) > 10) ? 1 : 0, 0);
            if (en_o === 1'b1) begin
                chk_int("en_o_width", int'(prev), 0);
                if (sb_q.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL en_o_unexpected: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk128("ciphertext", ciphertext, e.ct);
                    chk_int("latency", cyc, e.cyc);
                end
            end
            prev = en_o;
        end
    endtask

    // Call just after a negedge; returns at the negedge following the en edge.
    task automatic drive(input logic [127:0] pt, input logic [127:0] exp, input bit push);
        plaintext = pt;
        en = 1'b1;
        if (push) sb_q.push_back('{ct: exp, cyc: cyc + 23});
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        chk_int("drain_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        tb_sbox = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        expand(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        expand(1, 128'h5468617473206d79204b756e67204675);
        expand(2, 128'h000102030405060708090a0b0c0d0e0f);

        vec[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, ksel: 0,
                   ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vec[1] = '{pt: 128'h54776f204f6e65204e696e652054776f, ksel: 1,
                   ct: 128'h29c3505f571420f6402299b31a02d73a};
        vec[2] = '{pt: 128'h00112233445566778899aabbccddeeff, ksel: 2,
                   ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};

        chk128("sram_rk1", rk[1][1], 128'he232fcf191129188b159e4e6d679a293);
        chk128("sram_rk10", rk[1][10], 128'h28fddef86da4244accc0a4fe3b316f26);

        fork
            monitor();
        join_none

        reset = 1'b0;
        en = 1'b0;
        plaintext = '0;
        repeat (3) @(negedge clk);
        chk128("reset_ct", ciphertext, '0);
        chk_int("reset_rkno", int'(round_key_no), 0);
        chk_int("reset_en_o", int'(en_o), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Known vectors with round-index sequence check.
        for (int v = 0; v < 3; v++) begin
            sel = vec[v].ksel;
            drive(vec[v].pt, vec[v].ct, 1'b1);
            for (int k = 1; k <= 22; k++) begin
                chk_int("rkno_seq", int'(round_key_no), (k - 1) / 2);
                @(negedge clk);
            end
            @(negedge clk);
            chk_int("rkno_idle", int'(round_key_no), 0);
            wait_drain(10);
            @(negedge clk);
        end

        // Back-to-back: next en in the IDLE cycle right after en_o.
        sel = 1;
        drive(vec[1].pt, vec[1].ct, 1'b1);
        begin
            int n;
            n = 0;
            while (en_o !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk_int("b2b_done_seen", int'(en_o === 1'b1), 1);
        end
        @(negedge clk);
        sel = 0;
        drive(vec[0].pt, vec[0].ct, 1'b1);
        repeat (10) @(negedge clk);
        chk128("b2b_ct_held", ciphertext, vec[1].ct);
        repeat (10) @(negedge clk);
        chk128("b2b_ct_held_late", ciphertext, vec[1].ct);
        wait_drain(40);

        // en while busy (rounds 3..5) must be ignored.
        @(negedge clk);
        sel = 2;
        drive(vec[2].pt, vec[2].ct, 1'b1);
        repeat (6) @(negedge clk);
        en = 1'b1;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        repeat (6) @(negedge clk);
        en = 1'b0;
        wait_drain(40);
        repeat (5) @(negedge clk);
        chk128("busy_ct", ciphertext, vec[2].ct);

        // Reset during round 5 aborts; nothing queued, so any en_o is flagged.
        sel = 0;
        drive(vec[0].pt, vec[0].ct, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_int("abort_en_o", int'(en_o), 0);
        chk128("abort_ct", ciphertext, '0);
        chk_int("abort_rkno", int'(round_key_no), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk128("abort_ct_after", ciphertext, '0);
        drive(vec[0].pt, vec[0].ct, 1'b1);
        wait_drain(40);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
